// File: rtl/dac_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_pkg
//  Description : Shared types, widths and frame-building helper for the
//                DDS-to-SPI-DAC serialiser (dac_spi_tx).
//  Contents    : state_e  - FSM state enumeration (IDLE, SHIFT, GAP)
//                ST_*     - the same states as fixed-width constants
//                FRAME_W / SAMPLE_W / CTRL_W / PAD_W - frame field widths
//                build_frame() - {ctrl, sample, zero pad}
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_spi_pkg;

    localparam int FRAME_W  = 16;
    localparam int SAMPLE_W = 8;
    localparam int CTRL_W   = 4;
    localparam int PAD_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
    localparam logic [1:0] ST_GAP   = 2'(GAP);

    // Frame layout on the wire, MSB first: control nibble, sample, padding.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CTRL_W-1:0]   ctrl,
        input logic [SAMPLE_W-1:0] sample
    );
        return {ctrl, sample, {PAD_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_sclk_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sclk_tick_gen
//  Description : Modulo-SCLK_DIV counter producing a one-cycle tick every
//                SCLK_DIV enabled cycles. A synchronous clear restarts the
//                count so the first tick lands exactly SCLK_DIV cycles later.
//  Ports       : clkin  - system clock
//                rst_n  - asynchronous active-low reset
//                clr    - synchronous clear (priority over en)
//                en     - count enable
//                tick   - high in the last cycle of each SCLK_DIV period
//  Revision    : 1.0 - initial release
// ============================================================================
module sclk_tick_gen #(
    parameter int SCLK_DIV = 4
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SCLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx
//  Description : Accepts 8-bit DDS samples over valid/ready and sends each
//                one to an SPI DAC (mode 0, MSB first) as the 16-bit frame
//                {CTRL_WORD, sample, 4'b0000}. cs_n stays low for exactly
//                32*SCLK_DIV cycles and high for at least CS_IDLE ticks.
//  Build macro : DAC_SAMPLE_BUF_EN - adds a one-entry sample buffer so a new
//                sample can be taken while a frame is in flight and the
//                next frame starts straight out of GAP.
//  Ports       : clkin      - system clock
//                rst_n      - asynchronous active-low reset
//                s_data     - sample from DDS lookup
//                s_valid    - s_data valid
//                s_ready    - sample can be accepted this cycle
//                dac_cs_n   - DAC chip select, active low
//                dac_sclk   - DAC serial clock, idles low
//                dac_din    - DAC serial data, updated on SCLK falling edge
//                frame_done - one-cycle pulse as dac_cs_n returns high
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int               SCLK_DIV  = 4,
    parameter logic [CTRL_W-1:0] CTRL_WORD = 4'h0,
    parameter int               CS_IDLE   = 2
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                dac_cs_n,
    output logic                dac_sclk,
    output logic                dac_din,
    output logic                frame_done
);

    localparam int               GAP_W    = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);
    localparam logic [4:0]       BITS_END = 5'd16;

    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic [FRAME_W-1:0]  shreg;
    logic [4:0]          bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    logic                tick;
    logic                tick_en;
    logic                accept;
    logic                start;
    logic                shift_done;
    logic                gap_done;
    logic                ready_nx;
    logic                buf_full;
    logic [SAMPLE_W-1:0] buf_data;
    logic [SAMPLE_W-1:0] start_sample;
    logic [FRAME_W-1:0]  start_frame;

    assign accept  = s_valid && s_ready;
    assign tick_en = (state == ST_SHIFT) || (state == ST_GAP);

    // Frame ends on the falling toggle that follows the 16th rising edge.
    assign shift_done = (state == ST_SHIFT) && tick && dac_sclk && (bit_cnt == BITS_END);
    assign gap_done   = (state == ST_GAP) && tick && (gap_cnt == GAP_LAST);

    // Tick counter restarts on every frame start so SCLK phase is fixed
    // relative to the falling edge of cs_n.
    sclk_tick_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_tick (
        .clkin (clkin),
        .rst_n (rst_n),
        .clr   (start),
        .en    (tick_en),
        .tick  (tick)
    );

`ifdef DAC_SAMPLE_BUF_EN
    logic buf_load;
    logic buf_drain;
    logic buf_full_nx;

    // A sample taken in IDLE with an empty buffer goes straight to the
    // shifter; anything else is parked in the buffer.
    assign buf_load  = accept && !((state == ST_IDLE) && !buf_full);
    assign buf_drain = start && buf_full;

    always_comb begin
        buf_full_nx = buf_full;
        if (buf_load) begin
            buf_full_nx = 1'b1;
        end else if (buf_drain) begin
            buf_full_nx = 1'b0;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            buf_full <= buf_full_nx;
            if (buf_load) begin
                buf_data <= s_data;
            end
        end
    end

    // A full buffer at GAP exit starts the next frame in place of IDLE.
    assign start    = ((state == ST_IDLE) && (accept || buf_full)) || (gap_done && buf_full);
    assign ready_nx = !buf_full_nx;
`else
    assign buf_full = 1'b0;
    assign buf_data = '0;
    assign start    = (state == ST_IDLE) && accept;
    assign ready_nx = (state_nx == ST_IDLE);
`endif

    assign start_sample = buf_full ? buf_data : s_data;
    assign start_frame  = build_frame(CTRL_WORD, start_sample);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)      state_nx = ST_SHIFT;
            ST_SHIFT: if (shift_done) state_nx = ST_GAP;
            ST_GAP:   if (gap_done)   state_nx = start ? ST_SHIFT : ST_IDLE;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            s_ready    <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_din    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            s_ready    <= ready_nx;
            frame_done <= 1'b0;

            if (start) begin
                shreg    <= start_frame;
                bit_cnt  <= '0;
                dac_cs_n <= 1'b0;
                dac_sclk <= 1'b0;
                dac_din  <= start_frame[FRAME_W-1];
            end else if ((state == ST_SHIFT) && tick) begin
                if (!dac_sclk) begin
                    dac_sclk <= 1'b1;
                    bit_cnt  <= bit_cnt + 5'd1;
                end else begin
                    dac_sclk <= 1'b0;
                    if (bit_cnt == BITS_END) begin
                        dac_cs_n   <= 1'b1;
                        dac_din    <= 1'b0;
                        frame_done <= 1'b1;
                        gap_cnt    <= '0;
                    end else begin
                        // dac_din already shows shreg[15]; move to the next bit.
                        shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                        dac_din <= shreg[FRAME_W-2];
                    end
                end
            end else if ((state == ST_GAP) && tick) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_tx
//  Description : Self-checking bench for dac_spi_tx. A negedge monitor
//                rebuilds each cs_n window (bits on SCLK rising edges, low
//                time, frame_done) and compares against frames computed
//                from the samples the bench offered. Follows the build
//                macro DAC_SAMPLE_BUF_EN for the buffered-mode checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_tx;

    localparam int DIV   = 4;
    localparam int CSI   = 2;
    localparam int DIV_B = 2;
    localparam int CSI_B = 1;
`ifdef DAC_SAMPLE_BUF_EN
    localparam int GAP_EXP = CSI * DIV;
`else
    localparam int GAP_EXP = CSI * DIV + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, cs_n, sclk, din, fdone;
    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready, b_cs_n, b_sclk, b_din, b_fdone;

    always #5 clk = ~clk;

    dac_spi_tx #(.SCLK_DIV(DIV), .CTRL_WORD(4'h0), .CS_IDLE(CSI)) dut (
        .clkin(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_din(din), .frame_done(fdone)
    );

    dac_spi_tx #(.SCLK_DIV(DIV_B), .CTRL_WORD(4'hB), .CS_IDLE(CSI_B)) dut_b (
        .clkin(clk), .rst_n(rst_n), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .dac_cs_n(b_cs_n), .dac_sclk(b_sclk), .dac_din(b_din), .frame_done(b_fdone)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [3:0] ctrl, input logic [7:0] s);
        return 16'(ctrl) * 16'h1000 + 16'(s) * 16'h0010;
    endfunction

    // ---------------- monitor: one record per cs_n low window -------------
    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          low;
        logic        fd;
    } frm_t;

    frm_t        cap_q[$];
    int          gap_q[$];
    logic [7:0]  exp_q[$];
    bit          gap_arm = 1'b0;
    logic [15:0] m_sh = '0;
    int          m_nb = 0, m_low = 0, m_high = 0;
    logic        m_cs = 1'b1, m_sclk = 1'b0;

    always @(negedge clk) begin
        frm_t f;
        if (!cs_n) begin
            if (m_cs) begin
                if (gap_arm) gap_q.push_back(m_high);
                m_low = 0; m_sh = '0; m_nb = 0;
            end
            m_low++;
            if (sclk && !m_sclk) begin
                m_sh = {m_sh[14:0], din};
                m_nb++;
            end
        end else begin
            if (!m_cs) begin
                f.bits = m_sh; f.nbits = m_nb; f.low = m_low; f.fd = fdone;
                cap_q.push_back(f);
                m_high  = 0;
                gap_arm = 1'b1;
            end
            m_high++;
        end
        m_cs   = cs_n;
        m_sclk = sclk;
    end

    // ---------------- stimulus helpers -----------------------------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input bit hold);
        int t = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", 32'(t < 2000), 32'd1);
        if (t < 2000) exp_q.push_back(d);
        @(negedge clk);
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (cap_q.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("frame_wait", 32'(cap_q.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        frm_t       f;
        logic [7:0] e;
        if (cap_q.size() == 0 || exp_q.size() == 0) return;
        f = cap_q.pop_front();
        e = exp_q.pop_front();
        check({tag, "_bits"}, 32'(f.bits), 32'(exp_word(4'h0, e)));
        check({tag, "_nbits"}, f.nbits, 16);
        check({tag, "_cs_low"}, f.low, 32 * DIV);
        check({tag, "_fdone"}, 32'(f.fd), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + randomized sequence ---------------------
    initial begin
        logic [15:0] sh;
        int          nb, low, t, rises;
        logic        ps;
        logic [7:0]  e;
        frm_t        f;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        check("rst_fdone", 32'(fdone), 32'd0);
        check("rst_b_cs_n", 32'(b_cs_n), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(s_ready), 32'd1);

        // 1: single sample A5
        send(8'hA5, 1'b0);
        wait_frames(1);
        check("t1_word", 32'(exp_word(4'h0, 8'hA5)), 32'h0A50);
        check_frame("t1");

        // 2: CTRL_WORD=B instance, sample FF
        check("t2_b_ready", 32'(b_ready), 32'd1);
        b_data = 8'hFF; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0; b_data = 8'h00;
        sh = '0; nb = 0; low = 0; t = 0; ps = 1'b0;
        while (t < 400) begin
            if (!b_cs_n) begin
                low++;
                if (b_sclk && !ps) begin
                    sh = {sh[14:0], b_din};
                    nb++;
                end
            end else if (low > 0) begin
                break;
            end
            ps = b_sclk;
            @(negedge clk);
            t++;
        end
        check("t2_bits", 32'(sh), 32'hBFF0);
        check("t2_nbits", nb, 16);
        check("t2_cs_low", low, 32 * DIV_B);
        check("t2_fdone", 32'(b_fdone), 32'd1);

        // 3: s_valid held high across four samples
        wait_frames(0);
        gap_q.delete();
        gap_arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom_range(0, 255)), i < 3);
`ifndef DAC_SAMPLE_BUF_EN
            check("t3_ready_low", 32'(s_ready), 32'd0);
`endif
        end
        wait_frames(4);
        for (int i = 0; i < 4; i++) check_frame("t3");
        check("t3_gap_count", gap_q.size(), 3);
        while (gap_q.size() > 0) check("t3_gap", gap_q.pop_front(), GAP_EXP);

        // 4: async reset at the 8th SCLK rising edge
        repeat (20) @(negedge clk);
        send(8'($urandom_range(0, 255)), 1'b0);
        rises = 0; t = 0; ps = sclk;
        while (rises < 8 && t < 1000) begin
            ps = sclk;
            @(negedge clk);
            t++;
            if (sclk && !ps) rises++;
        end
        check("t4_reach_8th", rises, 8);
        #1 rst_n = 1'b0;
        #1;
        check("t4_cs_n", 32'(cs_n), 32'd1);
        check("t4_sclk", 32'(sclk), 32'd0);
        check("t4_din", 32'(din), 32'd0);
        check("t4_ready", 32'(s_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("t4_fdone", 32'(fdone), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_ready_after", 32'(s_ready), 32'd1);
        check("t4_partial_cnt", cap_q.size(), 1);
        if (cap_q.size() > 0 && exp_q.size() > 0) begin
            f = cap_q.pop_front();
            e = exp_q.pop_front();
            check("t4_partial_nbits", f.nbits, 8);
            check("t4_partial_bits", 32'(f.bits[7:0]), 32'(exp_word(4'h0, e) >> 8));
            check("t4_partial_fd", 32'(f.fd), 32'd0);
        end
        send(8'($urandom_range(0, 255)), 1'b0);
        wait_frames(1);
        check_frame("t4_next");

        // 5: s_data changes mid-frame
        send(8'h3C, 1'b0);
        s_data = 8'hC3;
        wait_frames(1);
        check_frame("t5");

        // Randomized samples with random idle spacing
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            send(8'($urandom_range(0, 255)), 1'b0);
            s_data = 8'($urandom_range(0, 255));
        end
        wait_frames(6);
        for (int i = 0; i < 6; i++) check_frame("rnd");

`ifdef DAC_SAMPLE_BUF_EN
        // 6: second sample offered mid-frame lands in the buffer
        repeat (60) @(negedge clk);
        gap_q.delete();
        gap_arm = 1'b0;
        send(8'h5A, 1'b0);
        repeat (40) @(negedge clk);
        check("t6_ready_mid", 32'(s_ready), 32'd1);
        send(8'($urandom_range(0, 255)), 1'b0);
        check("t6_ready_full", 32'(s_ready), 32'd0);
        t = 0;
        while (s_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("t6_drain_cs_low", 32'(cs_n), 32'd0);
        check("t6_drain_frames", cap_q.size(), 1);
        wait_frames(2);
        check_frame("t6_a");
        check_frame("t6_b");
        check("t6_gap_count", gap_q.size(), 1);
        if (gap_q.size() > 0) check("t6_gap", gap_q.pop_front(), CSI * DIV);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
